// File: rtl/event_counter_pkg.sv
// Shared definitions for the push-button event counter: switch field indices,
// debounce FSM encoding and the seven-segment glyph table.
package event_counter_pkg;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_REL_WAIT
  } db_state_e;

  localparam int SW_DIR     = 9;
  localparam int SW_LOAD    = 8;
  localparam int SW_VAL_MSB = 7;

  // Active-low segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/event_counter_button_debounce.sv
// Two-flop synchroniser plus debounce FSM for one active-low key; emits a
// single-cycle press pulse once the key has been low for DEBOUNCE_CYC samples.
module button_debounce
  import event_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk100_i,
  input  logic rstn_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  // With a one-sample window the first qualifying sample completes the edge.
  localparam bit            SINGLE   = (DEBOUNCE_CYC == 1);

  logic          sync1_q, sync2_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (!sync2_q) begin
          if (SINGLE) begin
            state_d = DB_HELD;
            press_d = 1'b1;
          end else begin
            state_d = DB_PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      DB_PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DB_HELD: begin
        if (sync2_q) begin
          if (SINGLE) begin
            state_d = DB_IDLE;
          end else begin
            state_d = DB_REL_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      DB_REL_WAIT: begin
        if (!sync2_q) begin
          state_d = DB_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

  assign press_o = press_q;

endmodule

// File: rtl/event_counter.sv
// Debounced step/clear counter with switch snapshot on LEDs and hex display
// of the count, one glyph per nibble.
module event_counter
  import event_counter_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int DIGITS       = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int WRAP         = 1
) (
  input  logic                  clk100_i,
  input  logic                  rstn_i,
  input  logic [1:0]            key_i,
  input  logic [9:0]            sw_i,
  output logic [9:0]            ledr_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  ovf_o,
  output logic [7*DIGITS-1:0]   hex_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             step_press, clr_press;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       ledr_q, ledr_d;
  logic             ovf_q, ovf_d;
  logic [4*DIGITS-1:0] cnt_pad;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (
    .clk100_i (clk100_i),
    .rstn_i   (rstn_i),
    .btn_n_i  (key_i[0]),
    .press_o  (step_press)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr (
    .clk100_i (clk100_i),
    .rstn_i   (rstn_i),
    .btn_n_i  (key_i[1]),
    .press_o  (clr_press)
  );

  generate
    if (CNT_W > SW_VAL_MSB + 1) begin : g_load_ext
      assign load_val = {{(CNT_W - SW_VAL_MSB - 1){1'b0}}, sw_i[SW_VAL_MSB:0]};
    end else begin : g_load_trunc
      assign load_val = sw_i[CNT_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      ledr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ledr_q <= ledr_d;
      ovf_q  <= ovf_d;
    end
  end

  // Clear outranks step; ovf only ever rises for the cycle after a boundary step.
  always_comb begin
    cnt_d  = cnt_q;
    ledr_d = ledr_q;
    ovf_d  = 1'b0;
    if (clr_press) begin
      cnt_d  = '0;
      ledr_d = '0;
    end else if (step_press) begin
      ledr_d = sw_i;
      if (sw_i[SW_LOAD]) begin
        cnt_d = load_val;
      end else if (!sw_i[SW_DIR]) begin
        if (cnt_q == CNT_MAX) begin
          ovf_d = 1'b1;
          if (WRAP != 0) cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          ovf_d = 1'b1;
          if (WRAP != 0) cnt_d = CNT_MAX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end
  end

  generate
    if (4 * DIGITS > CNT_W) begin : g_pad
      assign cnt_pad = {{(4 * DIGITS - CNT_W){1'b0}}, cnt_q};
    end else begin : g_nopad
      assign cnt_pad = cnt_q;
    end
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign hex_o[7*gi +: 7] = seg7_encode(cnt_pad[4*gi +: 4]);
    end
  endgenerate

  assign cnt_o  = cnt_q;
  assign ledr_o = ledr_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_event_counter.sv
// Directed bench for event_counter: a wrapping 8-bit instance, a saturating
// 8-bit instance and a wrapping 12-bit/3-digit instance, all with DEBOUNCE_CYC=4.
module tb_event_counter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  key_main, key_sat, key_wide;
  logic [9:0]  sw;

  logic [9:0]  ledr_main, ledr_sat, ledr_wide;
  logic [7:0]  cnt_main, cnt_sat;
  logic [11:0] cnt_wide;
  logic        ovf_main, ovf_sat, ovf_wide;
  logic [13:0] hex_main, hex_sat;
  logic [20:0] hex_wide;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GF = 7'b0001110;

  always #5 clk = ~clk;

  event_counter #(.CNT_W(8), .DIGITS(2), .DEBOUNCE_CYC(4), .WRAP(1)) u_main (
    .clk100_i(clk), .rstn_i(rstn), .key_i(key_main), .sw_i(sw),
    .ledr_o(ledr_main), .cnt_o(cnt_main), .ovf_o(ovf_main), .hex_o(hex_main)
  );

  event_counter #(.CNT_W(8), .DIGITS(2), .DEBOUNCE_CYC(4), .WRAP(0)) u_sat (
    .clk100_i(clk), .rstn_i(rstn), .key_i(key_sat), .sw_i(sw),
    .ledr_o(ledr_sat), .cnt_o(cnt_sat), .ovf_o(ovf_sat), .hex_o(hex_sat)
  );

  event_counter #(.CNT_W(12), .DIGITS(3), .DEBOUNCE_CYC(4), .WRAP(1)) u_wide (
    .clk100_i(clk), .rstn_i(rstn), .key_i(key_wide), .sw_i(sw),
    .ledr_o(ledr_wide), .cnt_o(cnt_wide), .ovf_o(ovf_wide), .hex_o(hex_wide)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic set_keys(input int inst, input logic [1:0] keys_n);
    case (inst)
      0:       key_main = keys_n;
      1:       key_sat  = keys_n;
      default: key_wide = keys_n;
    endcase
  endtask

  // Hold keys low for 'hold' cycles then release for 'hold' cycles, counting ovf cycles.
  task automatic press(input int inst, input logic [1:0] keys_n, input int hold, output int ovf_cnt);
    ovf_cnt = 0;
    set_keys(inst, keys_n);
    for (int i = 0; i < 2 * hold; i++) begin
      if (i == hold) set_keys(inst, 2'b11);
      @(negedge clk);
      case (inst)
        0:       ovf_cnt += int'(ovf_main);
        1:       ovf_cnt += int'(ovf_sat);
        default: ovf_cnt += int'(ovf_wide);
      endcase
    end
  endtask

  int ov;

  initial begin
    rstn = 1'b0; key_main = 2'b11; key_sat = 2'b11; key_wide = 2'b11; sw = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    check_eq("rst_cnt", cnt_main, 0);
    check_eq("rst_ledr", ledr_main, 0);
    check_eq("rst_ovf", ovf_main, 0);
    check_eq("rst_hex", hex_main, {G0, G0});
    check_eq("rst_hex_wide", hex_wide, {G0, G0, G0});

    // 1: first press, count updates one edge after the cycle-6 pulse
    key_main = 2'b10;
    repeat (6) @(negedge clk);
    check_eq("t1_cnt_before", cnt_main, 0);
    @(negedge clk);
    check_eq("t1_cnt_after", cnt_main, 1);
    check_eq("t1_hex", hex_main, {G0, G1});
    check_eq("t1_ledr", ledr_main, 0);
    repeat (13) @(negedge clk);
    check_eq("t1_no_repeat", cnt_main, 1);
    key_main = 2'b11;
    repeat (10) @(negedge clk);

    // 2: bounce then solid press, glitchy release
    for (int i = 0; i < 4; i++) begin
      key_main = (i % 2 == 0) ? 2'b10 : 2'b11;
      repeat (2) @(negedge clk);
    end
    check_eq("t2_bounce_nostep", cnt_main, 1);
    key_main = 2'b10;
    repeat (10) @(negedge clk);
    check_eq("t2_one_step", cnt_main, 2);
    key_main = 2'b11; repeat (2) @(negedge clk);
    key_main = 2'b10; repeat (2) @(negedge clk);
    key_main = 2'b11; repeat (10) @(negedge clk);
    check_eq("t2_glitch_nostep", cnt_main, 2);

    // 3: wrap / saturate at the top, wrap at the bottom
    sw = 10'h1FF;
    press(0, 2'b10, 10, ov);
    check_eq("t3_load_ff", cnt_main, 8'hFF);
    check_eq("t3_load_ovf", ov, 0);
    check_eq("t3_hex_ff", hex_main, {GF, GF});
    sw = 10'h000;
    press(0, 2'b10, 10, ov);
    check_eq("t3_wrap_cnt", cnt_main, 0);
    check_eq("t3_wrap_ovf_cycles", ov, 1);
    sw = 10'h200;
    press(0, 2'b10, 10, ov);
    check_eq("t3_down_wrap_cnt", cnt_main, 8'hFF);
    check_eq("t3_down_wrap_ovf", ov, 1);
    check_eq("t3_down_ledr", ledr_main, 10'h200);
    sw = 10'h1FF;
    press(1, 2'b10, 10, ov);
    check_eq("t3_sat_load", cnt_sat, 8'hFF);
    sw = 10'h000;
    press(1, 2'b10, 10, ov);
    check_eq("t3_sat_hold", cnt_sat, 8'hFF);
    check_eq("t3_sat_ovf_cycles", ov, 1);

    // 4: load then down-step
    sw = 10'h1A5;
    press(0, 2'b10, 10, ov);
    check_eq("t4_load_cnt", cnt_main, 8'hA5);
    check_eq("t4_load_ledr", ledr_main, 10'h1A5);
    check_eq("t4_load_ovf", ov, 0);
    check_eq("t4_hex_a5", hex_main, {GA, G5});
    sw = 10'h200;
    press(0, 2'b10, 10, ov);
    check_eq("t4_dec_cnt", cnt_main, 8'hA4);

    // 5: simultaneous step and clear
    sw = 10'h000;
    press(0, 2'b00, 10, ov);
    check_eq("t5_clr_cnt", cnt_main, 0);
    check_eq("t5_clr_ledr", ledr_main, 0);
    check_eq("t5_clr_ovf", ov, 0);

    // 6: reset in the middle of a debounce window discards the press
    press(0, 2'b10, 10, ov);
    check_eq("t6_pre_cnt", cnt_main, 1);
    key_main = 2'b10;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    key_main = 2'b11;
    @(negedge clk);
    rstn = 1'b1;
    check_eq("t6_rst_cnt", cnt_main, 0);
    repeat (20) @(negedge clk);
    check_eq("t6_no_pulse", cnt_main, 0);
    press(0, 2'b10, 10, ov);
    check_eq("t6_repress", cnt_main, 1);

    // 6: 12-bit, 3-digit instance walked up to 0x3F0
    sw = 10'h1FF;
    press(2, 2'b10, 10, ov);
    check_eq("t6w_load", cnt_wide, 12'h0FF);
    sw = 10'h000;
    for (int i = 0; i < 12'h3F0 - 12'h0FF; i++) press(2, 2'b10, 8, ov);
    check_eq("t6w_3f0", cnt_wide, 12'h3F0);
    press(2, 2'b10, 8, ov);
    check_eq("t6w_3f1", cnt_wide, 12'h3F1);
    check_eq("t6w_ovf", ov, 0);
    check_eq("t6w_hex", hex_wide, {G3, GF, G1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
